nibble_alu_seq: RTL

Multi-cycle sequencer that performs WIDTH-bit AND/OR/ADD/SUB/SLTU by driving an external combinational 4-bit ALU slice one nibble per cycle, LSB nibble first. Carry is chained across cycles through a register. It is the initiator side of the 4-bit ALU port set: it produces A, B, CarryIn, Binvert and Operation, and consumes Result and CarryOut. Upstream uses a valid/ready request; downstream uses a valid/ready response.

---
 rtl/nibble_alu_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/nibble_alu_seq.sv
// nibble_alu_seq: WIDTH-bit AND/OR/ADD/SUB/SLTU computed one nibble per cycle through an external 4-bit ALU slice.
// Optional feature: define NIBBLE_ALU_SEQ_ZERO_FLAG_EN to add the registered rsp_zero output.
module nibble_alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic             alu_carry_in,
   output logic             alu_binvert,
   output logic [1:0]       alu_operation,
   input  logic [3:0]       alu_result,
   input  logic             alu_carry_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry
`ifdef NIBBLE_ALU_SEQ_ZERO_FLAG_EN
   ,
   output logic             rsp_zero
`endif
);

   localparam int N    = WIDTH / 4;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLTU = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             rcarry_q, rcarry_d;
   logic [WIDTH-1:0] full;
   logic             complete;

   function automatic logic is_sub(input logic [2:0] op);
      return (op == OP_SUB) || (op == OP_SLTU);
   endfunction

   function automatic logic [1:0] alu_op_of(input logic [2:0] op);
      case (op)
         OP_AND:          return 2'b00;
         OP_OR:           return 2'b01;
         OP_ADD:          return 2'b10;
         OP_SUB, OP_SLTU: return 2'b10;
         default:         return 2'b00;
      endcase
   endfunction

   // SLTU collapses to the borrow bit; reserved ops report zero.
   function automatic logic [WIDTH-1:0] final_result(input logic [2:0] op,
                                                     input logic [WIDTH-1:0] acc,
                                                     input logic co);
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB: return acc;
         OP_SLTU:                       return {{(WIDTH-1){1'b0}}, ~co};
         default:                       return '0;
      endcase
   endfunction

   function automatic logic final_carry(input logic [2:0] op, input logic co);
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLTU: return co;
         default:                                return 1'b0;
      endcase
   endfunction

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      carry_d       = carry_q;
      a_d           = a_q;
      b_d           = b_q;
      op_d          = op_q;
      work_d        = work_q;
      res_d         = res_q;
      rcarry_d      = rcarry_q;
      complete      = 1'b0;
      req_ready     = 1'b0;
      rsp_valid     = 1'b0;
      alu_a         = 4'h0;
      alu_b         = 4'h0;
      alu_carry_in  = 1'b0;
      alu_binvert   = 1'b0;
      alu_operation = 2'b00;
      full          = work_q;
      full[{idx_q, 2'b00} +: 4] = alu_result;

      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_b;
               op_d    = req_op;
               idx_d   = '0;
               carry_d = is_sub(req_op);
               work_d  = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            alu_a         = a_q[{idx_q, 2'b00} +: 4];
            alu_b         = b_q[{idx_q, 2'b00} +: 4];
            alu_carry_in  = carry_q;
            alu_binvert   = is_sub(op_q);
            alu_operation = alu_op_of(op_q);
            work_d        = full;
            carry_d       = alu_carry_out;
            idx_d         = idx_q + IDXW'(1);
            if (idx_q == IDXW'(N - 1)) begin
               complete = 1'b1;
               res_d    = final_result(op_q, full, alu_carry_out);
               rcarry_d = final_carry(op_q, alu_carry_out);
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         res_q    <= '0;
         rcarry_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         res_q    <= res_d;
         rcarry_q <= rcarry_d;
      end
   end

   // Operand and partial-result storage needs no reset: only read while in RUN.
   always_ff @(posedge clk) begin
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      work_q <= work_d;
   end

   assign rsp_result = res_q;
   assign rsp_carry  = rcarry_q;

`ifdef NIBBLE_ALU_SEQ_ZERO_FLAG_EN
   logic zero_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        zero_q <= 1'b0;
      else if (complete) zero_q <= (res_d == '0);
   end

   assign rsp_zero = zero_q;
`endif

endmodule
